fib_encode_sched: RTL and testbench

//  Shares one random_encoder instance among NREQ requesters.
//  - Round-robin arbitration; launches one conversion at a time.
//  - Supplies the encoder's Fibonacci weight lookup (mema = F(cnt_a)).
//  - Returns the 64-bit Fibonacci word with the requester ID.
//  - A watchdog soft-resets a hung encoder.

---
 rtl/fib_sched_pkg.sv | 17 +
 rtl/fib_weight_rom.sv | 43 ++++
 rtl/fib_encode_sched.sv | 172 +++++++++++++++++
 tb/tb_fib_encode_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_sched_pkg.sv
// Shared types and constants for the Fibonacci encoder scheduler.
package fib_sched_pkg;

    localparam int          FIB_W       = 16;
    localparam int          FIB_MAX_IDX = 22;
    localparam logic [15:0] FIB_SAT     = 16'hFFFF;
    localparam int          CNT_W       = 10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_RESP    = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

endpackage

// File: rtl/fib_weight_rom.sv
// Fibonacci weight table: F(0)=1, F(1)=2, F(i)=F(i-1)+F(i-2), saturating
// to FIB_SAT beyond F(22)=46368, the last term that fits in 16 bits.
module fib_weight_rom
    import fib_sched_pkg::*;
(
    input  logic [CNT_W-1:0] idx,
    output logic [FIB_W-1:0] weight
);

    // Table lookup; anything past the largest representable term saturates.
    always_comb begin
        weight = FIB_SAT;
        if (idx <= CNT_W'(FIB_MAX_IDX)) begin
            case (idx)
                10'd0:   weight = 16'd1;
                10'd1:   weight = 16'd2;
                10'd2:   weight = 16'd3;
                10'd3:   weight = 16'd5;
                10'd4:   weight = 16'd8;
                10'd5:   weight = 16'd13;
                10'd6:   weight = 16'd21;
                10'd7:   weight = 16'd34;
                10'd8:   weight = 16'd55;
                10'd9:   weight = 16'd89;
                10'd10:  weight = 16'd144;
                10'd11:  weight = 16'd233;
                10'd12:  weight = 16'd377;
                10'd13:  weight = 16'd610;
                10'd14:  weight = 16'd987;
                10'd15:  weight = 16'd1597;
                10'd16:  weight = 16'd2584;
                10'd17:  weight = 16'd4181;
                10'd18:  weight = 16'd6765;
                10'd19:  weight = 16'd10946;
                10'd20:  weight = 16'd17711;
                10'd21:  weight = 16'd28657;
                10'd22:  weight = 16'd46368;
                default: weight = FIB_SAT;
            endcase
        end
    end

endmodule

// File: rtl/fib_encode_sched.sv
// Round-robin scheduler sharing one random_encoder among NREQ channels.
// Launches one conversion at a time, serves the encoder's weight lookup,
// returns the 64-bit Fibonacci word tagged with the owning channel, and
// soft-resets the encoder through a watchdog if it never completes.
module fib_encode_sched
    import fib_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 1023,
    parameter int RST_CYC = 2
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*FIB_W-1:0] req_data,
    output logic [NREQ-1:0]       grant,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [63:0]           rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  enc_rst,
    output logic                  enc_en_encode,
    output logic [FIB_W-1:0]      enc_input_binary,
    output logic [FIB_W-1:0]      enc_mema,
    input  logic [CNT_W-1:0]      enc_cnt_a,
    input  logic                  enc_convert_done,
    input  logic [63:0]           enc_fib_random
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    state_t          state_q;
    state_t          state_d;
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_nxt;
    logic [WD_W-1:0] wdog_q;
    logic [RC_W-1:0] rc_q;
    logic            cd_q;
    logic            soft_rst_q;

    logic            win_found;
    logic [ID_W-1:0] win_idx;
    logic [ID_W:0]   arb_sum;
    logic [ID_W:0]   ptr_sum;

    logic            done_evt;
    logic            wdog_hit;
    logic            rc_last;

    // Only a rising edge of convert_done counts, so a level left high from
    // an earlier conversion cannot complete the next one.
    assign done_evt = enc_convert_done & ~cd_q;
    assign wdog_hit = (wdog_q == WD_W'(TIMEOUT));
    assign rc_last  = (rc_q == RC_W'(RST_CYC - 1));

    assign busy    = (state_q != S_IDLE);
    assign enc_rst = rst & ~soft_rst_q;

    fib_weight_rom u_rom (
        .idx    (enc_cnt_a),
        .weight (enc_mema)
    );

    // Round-robin pick: first active request at or after ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        arb_sum   = '0;
        ptr_sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            arb_sum = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (arb_sum >= (ID_W+1)'(NREQ)) begin
                arb_sum = arb_sum - (ID_W+1)'(NREQ);
            end
            if (!win_found && req[arb_sum[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = arb_sum[ID_W-1:0];
            end
        end
        ptr_sum = {1'b0, win_idx} + (ID_W+1)'(1);
        if (ptr_sum >= (ID_W+1)'(NREQ)) begin
            ptr_sum = ptr_sum - (ID_W+1)'(NREQ);
        end
        ptr_nxt = ptr_sum[ID_W-1:0];
    end

    // Next-state logic for the launch / wait / respond / recover sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (win_found) state_d = S_LAUNCH;
            S_LAUNCH:  state_d = S_WAIT;
            S_WAIT: begin
                if (done_evt)      state_d = S_RESP;
                else if (wdog_hit) state_d = S_RECOVER;
            end
            S_RECOVER: if (rc_last) state_d = S_RESP;
            S_RESP:    if (rsp_valid && rsp_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Grant/launch, watchdog, recovery timing and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q            <= '0;
            wdog_q           <= '0;
            rc_q             <= '0;
            cd_q             <= 1'b0;
            soft_rst_q       <= 1'b0;
            grant            <= '0;
            enc_en_encode    <= 1'b0;
            enc_input_binary <= '0;
            rsp_valid        <= 1'b0;
            rsp_id           <= '0;
            rsp_data         <= '0;
            rsp_err          <= 1'b0;
        end else begin
            cd_q          <= enc_convert_done;
            grant         <= '0;
            enc_en_encode <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        grant[win_idx]   <= 1'b1;
                        enc_en_encode    <= 1'b1;
                        enc_input_binary <= req_data[{win_idx, 4'b0000} +: FIB_W];
                        rsp_id           <= win_idx;
                        ptr_q            <= ptr_nxt;
                    end
                end
                S_LAUNCH: wdog_q <= '0;
                S_WAIT: begin
                    if (done_evt) begin
                        rsp_data  <= enc_fib_random;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else if (wdog_hit) begin
                        rsp_data   <= '0;
                        rsp_err    <= 1'b1;
                        soft_rst_q <= 1'b1;
                        rc_q       <= '0;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end
                S_RECOVER: begin
                    if (rc_last) begin
                        soft_rst_q <= 1'b0;
                        rsp_valid  <= 1'b1;
                    end else begin
                        rc_q <= rc_q + RC_W'(1);
                    end
                end
                S_RESP: if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_encode_sched.sv
// Directed bench for fib_encode_sched; the encoder is played by the bench.
module tb_fib_encode_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  grant;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        enc_rst;
    logic        enc_en_encode;
    logic [15:0] enc_input_binary;
    logic [15:0] enc_mema;
    logic [9:0]  enc_cnt_a;
    logic        enc_convert_done;
    logic [63:0] enc_fib_random;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fib_encode_sched dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .req_data         (req_data),
        .grant            (grant),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_id           (rsp_id),
        .rsp_data         (rsp_data),
        .rsp_err          (rsp_err),
        .busy             (busy),
        .enc_rst          (enc_rst),
        .enc_en_encode    (enc_en_encode),
        .enc_input_binary (enc_input_binary),
        .enc_mema         (enc_mema),
        .enc_cnt_a        (enc_cnt_a),
        .enc_convert_done (enc_convert_done),
        .enc_fib_random   (enc_fib_random)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // One full conversion: grant, launch, encoder done after delay, accept.
    task automatic conv(input string tag, input logic [3:0] exp_grant, input logic [1:0] exp_id,
                        input logic [15:0] exp_data, input logic [3:0] req_after,
                        input logic [63:0] result, input int delay);
        tick;
        chk({tag, "_grant"}, grant, exp_grant);
        chk({tag, "_en"}, enc_en_encode, 1'b1);
        chk({tag, "_opnd"}, enc_input_binary, exp_data);
        req = req_after;
        tick;
        chk({tag, "_gdrop"}, grant, 4'b0000);
        chk({tag, "_endrop"}, enc_en_encode, 1'b0);
        repeat (delay) tick;
        enc_fib_random   = result;
        enc_convert_done = 1'b1;
        tick;
        chk({tag, "_vld"}, rsp_valid, 1'b1);
        chk({tag, "_id"}, rsp_id, exp_id);
        chk({tag, "_data"}, rsp_data, result);
        chk({tag, "_err"}, rsp_err, 1'b0);
        chk({tag, "_opnd_hold"}, enc_input_binary, exp_data);
        enc_convert_done = 1'b0;
        rsp_ready        = 1'b1;
        tick;
        chk({tag, "_acc"}, rsp_valid, 1'b0);
        chk({tag, "_idle"}, busy, 1'b0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [9:0]  sweep_idx [6];
        logic [15:0] sweep_exp [6];
        int          cnt;

        rst = 1'b0; req = '0; req_data = '0; rsp_ready = 1'b0;
        enc_cnt_a = '0; enc_convert_done = 1'b0; enc_fib_random = '0;
        repeat (3) tick;

        // Reset state
        chk("rst_grant", grant, 4'b0000);
        chk("rst_vld", rsp_valid, 1'b0);
        chk("rst_data", rsp_data, 64'h0);
        chk("rst_err", rsp_err, 1'b0);
        chk("rst_id", rsp_id, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_encrst", enc_rst, 1'b0);
        chk("rst_en", enc_en_encode, 1'b0);
        chk("rst_opnd", enc_input_binary, 16'h0);
        rst = 1'b1;
        tick;
        chk("rel_encrst", enc_rst, 1'b1);

        // Weight table sweep
        sweep_idx = '{10'd0, 10'd1, 10'd2, 10'd22, 10'd23, 10'd1023};
        sweep_exp = '{16'd1, 16'd2, 16'd3, 16'd46368, 16'hFFFF, 16'hFFFF};
        for (int i = 0; i < 6; i++) begin
            enc_cnt_a = sweep_idx[i];
            #1;
            chk($sformatf("mema_%0d", sweep_idx[i]), enc_mema, sweep_exp[i]);
        end

        // Round robin over all four channels, then wrap to ch0
        req_data = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
        req      = 4'b1111;
        conv("rr0", 4'b0001, 2'd0, 16'h0100, 4'b1111, 64'hA0, 3);
        conv("rr1", 4'b0010, 2'd1, 16'h0101, 4'b1111, 64'hA1, 3);
        conv("rr2", 4'b0100, 2'd2, 16'h0102, 4'b1111, 64'hA2, 3);
        conv("rr3", 4'b1000, 2'd3, 16'h0103, 4'b1111, 64'hA3, 3);
        conv("rr4", 4'b0001, 2'd0, 16'h0100, 4'b0000, 64'hA4, 3);

        // Channel 1, operand 4 -> 4 = F(2)+F(0) -> bits 2 and 0
        req_data = '0;
        req_data[31:16] = 16'd4;
        req = 4'b0010;
        conv("t1", 4'b0010, 2'd1, 16'd4, 4'b0000, 64'h5, 18);

        // Back-pressure: response held, competing request waits
        req_data[15:0] = 16'd7;
        req = 4'b0001;
        tick;
        chk("bp_grant", grant, 4'b0001);
        req = 4'b1000;
        req_data[63:48] = 16'h0033;
        tick;
        enc_fib_random = 64'h1234; enc_convert_done = 1'b1;
        tick;
        chk("bp_vld", rsp_valid, 1'b1);
        enc_convert_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk($sformatf("bp_hold_vld_%0d", i), rsp_valid, 1'b1);
            chk($sformatf("bp_hold_data_%0d", i), rsp_data, 64'h1234);
            chk($sformatf("bp_nogrant_%0d", i), grant, 4'b0000);
        end
        rsp_ready = 1'b1;
        tick;
        chk("bp_acc", rsp_valid, 1'b0);
        chk("bp_acc_nogrant", grant, 4'b0000);
        rsp_ready = 1'b0;
        tick;
        chk("bp_next_grant", grant, 4'b1000);
        chk("bp_next_opnd", enc_input_binary, 16'h0033);
        req = 4'b0000;
        tick;
        enc_fib_random = 64'h77; enc_convert_done = 1'b1;
        tick;
        chk("bp2_id", rsp_id, 2'd3);
        chk("bp2_data", rsp_data, 64'h77);
        enc_convert_done = 1'b0; rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;

        // Watchdog: encoder never finishes
        req_data[47:32] = 16'd9;
        req = 4'b0100;
        tick;
        chk("wd_grant", grant, 4'b0100);
        req = 4'b0000;
        tick;
        cnt = 0;
        while (enc_rst === 1'b1 && cnt < 1100) begin
            tick;
            cnt++;
        end
        chk("wd_cycles", cnt, 1024);
        chk("wd_err", rsp_err, 1'b1);
        chk("wd_novld", rsp_valid, 1'b0);
        tick;
        chk("wd_encrst_2nd", enc_rst, 1'b0);
        chk("wd_novld2", rsp_valid, 1'b0);
        tick;
        chk("wd_encrst_rel", enc_rst, 1'b1);
        chk("wd_vld", rsp_valid, 1'b1);
        chk("wd_err_rsp", rsp_err, 1'b1);
        chk("wd_data", rsp_data, 64'h0);
        chk("wd_id", rsp_id, 2'd2);
        rsp_ready = 1'b1;
        tick;
        chk("wd_acc", rsp_valid, 1'b0);
        rsp_ready = 1'b0;
        req_data[15:0] = 16'd3;
        req = 4'b0001;
        conv("after_wd", 4'b0001, 2'd0, 16'd3, 4'b0000, 64'h9, 2);

        // convert_done already high on entry to S_WAIT; zero operand
        req_data[15:0] = 16'd0;
        req = 4'b0001;
        tick;
        chk("lvl_grant", grant, 4'b0001);
        req = 4'b0000;
        enc_fib_random = 64'h0; enc_convert_done = 1'b1;
        tick;
        repeat (3) tick;
        chk("edge_only", rsp_valid, 1'b0);
        enc_convert_done = 1'b0;
        tick;
        enc_convert_done = 1'b1;
        tick;
        chk("zero_vld", rsp_valid, 1'b1);
        chk("zero_data", rsp_data, 64'h0);
        enc_convert_done = 1'b0; rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;

        // Reset during S_WAIT
        req_data[31:16] = 16'h0055;
        req = 4'b0010;
        tick;
        chk("mid_grant", grant, 4'b0010);
        req = 4'b0000;
        tick;
        repeat (5) tick;
        chk("mid_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("mr_busy", busy, 1'b0);
        chk("mr_encrst", enc_rst, 1'b0);
        chk("mr_id", rsp_id, 2'd0);
        chk("mr_opnd", enc_input_binary, 16'h0);
        tick;
        chk("mr_busy2", busy, 1'b0);
        chk("mr_grant", grant, 4'b0000);
        chk("mr_vld", rsp_valid, 1'b0);
        rst = 1'b1;
        tick;
        req_data[63:48] = 16'h0066;
        req = 4'b1010;
        conv("post_rst", 4'b0010, 2'd1, 16'h0055, 4'b0000, 64'hBB, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
